// File: rtl/imem_load_if.sv
// Instruction-memory loader bus bundle.
// Groups the fetch-side address, the load request, the UART byte stream,
// the instruction-memory port and the CPU control/status flags.
//   master : drives fetch_addr, load_req, rx_valid, rx_data
//   slave  : drives imem_addr, imem_we, imem_wdata, cpu_hold, cpu_restart,
//            load_busy, load_err
interface imem_load_if #(
    parameter int unsigned ADDR_W = 14
);
    logic [ADDR_W-1:0] fetch_addr;
    logic              load_req;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              cpu_restart;
    logic              load_busy;
    logic              load_err;

    modport master (
        output fetch_addr, load_req, rx_valid, rx_data,
        input  imem_addr, imem_we, imem_wdata, cpu_hold, cpu_restart,
               load_busy, load_err
    );

    modport slave (
        input  fetch_addr, load_req, rx_valid, rx_data,
        output imem_addr, imem_we, imem_wdata, cpu_hold, cpu_restart,
               load_busy, load_err
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load sequencer and port arbiter.
// Passes the fetch address to the memory port while idle; on load_req it
// freezes the CPU, assembles UART bytes (16-bit LE word count, then LE data
// words) into 32-bit words written from address 0 upward, and releases the
// CPU with a one-cycle restart pulse.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : imem_load_if slave (fetch/request/UART inputs, memory port and
//            CPU control/status outputs)
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN adds a trailing XOR checksum
// byte over all preceding bytes; a mismatch ends in the error state.
module imem_load_ctrl #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MAX_WORDS = 16384
) (
    input logic        clock,
    input logic        reset,
    imem_load_if.slave bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOAD_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_remain;
    logic [7:0]        r_len_lo;
    logic [23:0]       r_word;
    logic [1:0]        r_bcnt;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_hold;
    logic              r_restart;
    logic              r_busy;
    logic              r_err;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic              w_csum_ok;
    assign w_csum_ok = (bus.rx_data == r_csum);
`endif

    logic [CNT_W-1:0] w_len;
    logic             w_last;
    assign w_len  = {bus.rx_data, r_len_lo};
    assign w_last = (r_remain == CNT_W'(1));

    // Memory port belongs to the loader whenever the CPU is held.
    assign bus.imem_addr   = r_hold ? r_ptr : bus.fetch_addr;
    assign bus.imem_we     = r_we;
    assign bus.imem_wdata  = r_wdata;
    assign bus.cpu_hold    = r_hold;
    assign bus.cpu_restart = r_restart;
    assign bus.load_busy   = r_busy;
    assign bus.load_err    = r_err;

    // Load sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_remain  <= '0;
            r_len_lo  <= '0;
            r_word    <= '0;
            r_bcnt    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_hold    <= 1'b0;
            r_restart <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_we      <= 1'b0;
            r_restart <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (bus.load_req) begin
                        r_state <= S_LEN0;
                        r_hold  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_ptr   <= '0;
                        r_bcnt  <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (bus.rx_valid) begin
                        r_len_lo <= bus.rx_data;
                        r_state  <= S_LEN1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        r_csum   <= r_csum ^ bus.rx_data;
`endif
                    end
                end
                S_LEN1: begin
                    if (bus.rx_valid) begin
                        r_remain <= w_len;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        r_csum   <= r_csum ^ bus.rx_data;
`endif
                        if (w_len == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                            r_state   <= S_CSUM;
`else
                            r_state   <= S_DONE;
                            r_restart <= 1'b1;
`endif
                        end else if (32'(w_len) > 32'(MAX_WORDS)) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.rx_data;
`endif
                        case (r_bcnt)
                            2'd0: r_word[7:0]   <= bus.rx_data;
                            2'd1: r_word[15:8]  <= bus.rx_data;
                            2'd2: r_word[23:16] <= bus.rx_data;
                            default: begin
                                r_wdata <= {bus.rx_data, r_word};
                                r_we    <= 1'b1;
                                r_state <= S_WRITE;
                            end
                        endcase
                        r_bcnt <= r_bcnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_ptr    <= r_ptr + ADDR_W'(1);
                    r_remain <= r_remain - CNT_W'(1);
                    if (w_last) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        // A byte landing here is already the checksum byte.
                        if (bus.rx_valid) begin
                            if (w_csum_ok) begin
                                r_state   <= S_DONE;
                                r_restart <= 1'b1;
                            end else begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_state <= S_CSUM;
                        end
`else
                        r_state   <= S_DONE;
                        r_restart <= 1'b1;
`endif
                    end else begin
                        r_state <= S_DATA;
                        // Back-to-back byte becomes byte 0 of the next word.
                        if (bus.rx_valid) begin
                            r_word[7:0] <= bus.rx_data;
                            r_bcnt      <= 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                            r_csum      <= r_csum ^ bus.rx_data;
`endif
                        end
                    end
                end
`ifdef IMEM_LOAD_CHECKSUM_EN
                S_CSUM: begin
                    if (bus.rx_valid) begin
                        if (w_csum_ok) begin
                            r_state   <= S_DONE;
                            r_restart <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: directed scenarios plus randomized
// loads checked against a byte-stream model of the expected memory writes.
module tb_imem_load_ctrl;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned MAX_WORDS = 16384;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    imem_load_if #(.ADDR_W(ADDR_W)) bus();

    imem_load_ctrl #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Monitor: log writes, restart pulses and cycle stamps at the falling edge.
    int   cyc           = 0;
    wr_t  got_q[$];
    int   restart_cnt   = 0;
    int   restart_cyc   = -1;
    int   last_rx_cyc   = -1;
    int   hold_fall_cyc = -1;
    int   consec_we     = 0;
    logic prev_we       = 1'b0;
    logic prev_hold     = 1'b0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.rx_valid) last_rx_cyc = cyc;
        if (bus.imem_we) begin
            got_q.push_back('{addr: bus.imem_addr, data: bus.imem_wdata});
            if (prev_we) consec_we++;
        end
        if (bus.cpu_restart) begin
            restart_cnt++;
            restart_cyc = cyc;
        end
        if (prev_hold && !bus.cpu_hold) hold_fall_cyc = cyc;
        prev_we   = bus.imem_we;
        prev_hold = bus.cpu_hold;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_req();
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Full load: model the byte stream and the writes it must produce.
    task automatic run_load(input logic [31:0] words[$], input int maxgap, input int req_at);
        logic [7:0]  bytes[$];
        logic [31:0] w;
        logic [7:0]  x;
        int n, base, rbase, lat;
        n = words.size();
        bytes.push_back(8'(n));
        bytes.push_back(8'(n >> 8));
        foreach (words[i]) begin
            w = words[i];
            for (int k = 0; k < 4; k++) bytes.push_back(w[8*k +: 8]);
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        x = '0;
        foreach (bytes[i]) x = x ^ bytes[i];
        bytes.push_back(x);
        lat = 1;
`else
        x = '0;
        lat = (n > 0) ? 2 : 1;
`endif
        base  = got_q.size();
        rbase = restart_cnt;
        pulse_req();
        check("hold_rise", 64'(bus.cpu_hold), 64'(1));
        check("err_clear", 64'(bus.load_err), 64'(0));
        check("busy_rise", 64'(bus.load_busy), 64'(1));
        check("hold_addr", 64'(bus.imem_addr), 64'(0));
        foreach (bytes[i]) begin
            if (i == req_at) pulse_req();
            send_byte(bytes[i], int'($urandom_range(maxgap, 0)));
        end
        for (int k = 0; k < 8; k++) if (bus.cpu_hold) tick();
        tick();
        check("end_hold", 64'(bus.cpu_hold), 64'(0));
        check("end_busy", 64'(bus.load_busy), 64'(0));
        check("wr_count", 64'(got_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got_q.size()) begin
                check("wr_addr", 64'(got_q[base+i].addr), 64'(i));
                check("wr_data", 64'(got_q[base+i].data), 64'(words[i]));
            end
        end
        check("restart_cnt", 64'(restart_cnt - rbase), 64'(1));
        check("restart_lat", 64'(restart_cyc - last_rx_cyc), 64'(lat));
        check("hold_fall", 64'(hold_fall_cyc - restart_cyc), 64'(1));
    endtask

    initial begin
        logic [31:0] wq[$];
        int          nb;
        int          rb;
        logic [7:0]  bad;

        bus.fetch_addr = 14'h0123;
        bus.load_req   = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = '0;
        #2;
        // Reset state while reset is held low.
        check("rst_addr",    64'(bus.imem_addr),   64'h0123);
        check("rst_we",      64'(bus.imem_we),     64'(0));
        check("rst_wdata",   64'(bus.imem_wdata),  64'(0));
        check("rst_hold",    64'(bus.cpu_hold),    64'(0));
        check("rst_restart", 64'(bus.cpu_restart), 64'(0));
        check("rst_busy",    64'(bus.load_busy),   64'(0));
        check("rst_err",     64'(bus.load_err),    64'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_addr", 64'(bus.imem_addr), 64'h0123);
        check("idle_hold", 64'(bus.cpu_hold),  64'(0));
        bus.fetch_addr = 14'h2ABC;
        #1;
        check("idle_follow", 64'(bus.imem_addr), 64'h2ABC);

        // Bytes in IDLE are ignored.
        nb = got_q.size();
        send_byte(8'h55, 1);
        check("idle_rx", 64'(bus.load_busy), 64'(0));

        // Two-word load with fixed payload.
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'hDEADBEEF);
        run_load(wq, 1, -1);

        // Back-to-back bytes.
        wq.delete();
        wq.push_back($urandom);
        wq.push_back($urandom);
        run_load(wq, 0, -1);
        check("no_consec_we", 64'(consec_we), 64'(0));

        // Oversize length 0x4001.
        nb = got_q.size();
        pulse_req();
        send_byte(8'h01, 0);
        send_byte(8'h40, 0);
        check("ovr_err",  64'(bus.load_err),  64'(1));
        check("ovr_hold", 64'(bus.cpu_hold),  64'(1));
        check("ovr_busy", 64'(bus.load_busy), 64'(0));
        send_byte(8'hAA, 0);
        tick();
        check("ovr_sticky", 64'(bus.load_err), 64'(1));
        check("ovr_nowr",   64'(got_q.size() - nb), 64'(0));

        // Zero length, started from the error state.
        wq.delete();
        run_load(wq, 1, -1);

        // load_req during DATA has no effect.
        wq.delete();
        wq.push_back($urandom);
        run_load(wq, 1, 4);

        // Count exactly MAX_WORDS is accepted; then reset mid-word.
        rb = restart_cnt;
        pulse_req();
        send_byte(8'h00, 0);
        send_byte(8'h40, 1);
        check("max_busy", 64'(bus.load_busy), 64'(1));
        check("max_err",  64'(bus.load_err),  64'(0));
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_hold", 64'(bus.cpu_hold),  64'(0));
        check("mid_rst_busy", 64'(bus.load_busy), 64'(0));
        check("mid_rst_addr", 64'(bus.imem_addr), 64'h2ABC);
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_norestart", 64'(restart_cnt - rb), 64'(0));
        wq.delete();
        wq.push_back($urandom);
        run_load(wq, 2, -1);

`ifdef IMEM_LOAD_CHECKSUM_EN
        // Bad checksum ends in ERR with no restart.
        rb = restart_cnt;
        nb = got_q.size();
        pulse_req();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        bad = 8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'hFF;
        send_byte(bad, 0);
        tick();
        check("csum_err",   64'(bus.load_err),  64'(1));
        check("csum_hold",  64'(bus.cpu_hold),  64'(1));
        check("csum_norst", 64'(restart_cnt - rb), 64'(0));
        check("csum_wr",    64'(got_q.size() - nb), 64'(1));
`else
        bad = 8'h00;
`endif

        // Randomized loads.
        for (int t = 0; t < 8; t++) begin
            wq.delete();
            nb = int'($urandom_range(6, 0));
            for (int i = 0; i < nb; i++) wq.push_back($urandom);
            bus.fetch_addr = 14'($urandom);
            run_load(wq, 2, (nb > 0) ? int'($urandom_range(2 + 4*nb, 3)) : -1);
        end
        check("no_consec_we_all", 64'(consec_we), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Sequencer and port arbiter for the instruction memory. It owns the single instruction-memory port and normally passes the fetch unit's word address straight through. On request, it freezes the CPU, assembles a byte stream from the UART receiver into 32-bit words, and writes them from word 0 upward. When the load finishes it releases the CPU with a restart pulse so the PC returns to 0.

## Interface
Parameters:
- `ADDR_W`, 14: instruction-memory word-address width (byte address bits [15:2]).
- `MAX_WORDS`, 16384: largest accepted word count; must be ≤ 2^ADDR_W.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_addr`  in  ADDR_W  word address from the fetch unit (PC[15:2]).
- `load_req`  in  1  single-cycle request to start a program load.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `imem_addr`  out  ADDR_W  address to the instruction-memory port.
- `imem_we`  out  1  write enable to the instruction-memory port.
- `imem_wdata`  out  32  write data to the instruction-memory port.
- `cpu_hold`  out  1  freezes PC update and register/memory writes while high.
- `cpu_restart`  out  1  one-cycle pulse after a successful load; the PC is forced to 0.
- `load_busy`  out  1  high in every state except IDLE and ERR.
- `load_err`  out  1  sticky error flag; cleared by the next accepted `load_req`.

## Operation
- States: IDLE, LEN0, LEN1, DATA, WRITE, (CSUM), DONE, ERR.
- IDLE:
  - `imem_addr = fetch_addr`; `cpu_hold = 0`.
  - `rx_valid` is ignored.
  - `load_req` → LEN0. This sets `cpu_hold = 1`, clears `load_err` and zeroes the word pointer and byte counter.
- LEN0 / LEN1: the first two bytes form a 16-bit word count, little-endian (LEN0 = low byte).
- Leaving LEN1, the count decides the next state:
  - count = 0 → DONE (CSUM if the checksum feature is compiled in).
  - count > `MAX_WORDS` → ERR.
  - otherwise → DATA.
- DATA:
  - Bytes are packed little-endian: byte k of a word goes to bits [8k+7:8k].
  - The 4th byte → WRITE.
- WRITE (one cycle):
  - `imem_we = 1`, `imem_addr` = word pointer, `imem_wdata` = assembled word.
  - The word pointer increments.
  - If the last word was written → DONE/CSUM; else → DATA.
  - A `rx_valid` arriving in WRITE is captured as byte 0 of the next word; no byte is dropped.
- Whenever `cpu_hold` = 1 (every state except IDLE), `imem_addr` = word pointer; `fetch_addr` is ignored.
- DONE (one cycle): `cpu_restart = 1`, `cpu_hold` stays 1, then → IDLE.
- ERR:
  - `load_err = 1`, `cpu_hold = 1`, no writes.
  - Stays in ERR until `load_req` → LEN0.
- `load_req` while `load_busy` is ignored.
- Word pointer arithmetic is ADDR_W bits wide. With count = `MAX_WORDS` = 2^ADDR_W, the last write is to address 2^ADDR_W−1, and the pointer wraps to 0 without a further write.

## Timing
- Reset values:
  - State IDLE.
  - `imem_we`, `cpu_hold`, `cpu_restart`, `load_busy`, `load_err` = 0.
  - `imem_wdata` = 0; `imem_addr` follows `fetch_addr`.
- `cpu_hold` rises the cycle after `load_req` is sampled.
- `imem_we` is asserted exactly 1 cycle after the edge that samples the 4th byte of a word.
- `cpu_restart` occurs exactly 1 cycle after the final write (or after the final length/checksum byte). `cpu_hold` falls on the following edge.
- `rx_valid` may be asserted on consecutive cycles; each strobe is consumed exactly once.
- Reset asserted mid-load: immediate return to IDLE with the reset values above, and `cpu_hold` drops. Words already written remain in memory.

## Configuration
- `IMEM_LOAD_CHECKSUM_EN` defined:
  - After the last data byte (or after LEN1 when count = 0), one extra byte is received in CSUM.
  - It must equal the XOR of all preceding bytes, including the length bytes.
  - Match → DONE; mismatch → ERR, with no `cpu_restart`.
- Not defined: the CSUM state does not exist and DATA/LEN1 go directly to DONE.

## Test plan
- Reset sequencing: with `reset` low, set `fetch_addr` = 0x0123 → `imem_addr` = 0x0123 and all flags are 0. Raise `reset` → behaviour is unchanged.
- Two-word load:
  - Stimulus: `load_req`, then bytes 02 00 | 78 56 34 12 | EF BE AD DE.
  - Required writes: 0x12345678 at address 0, then 0xDEADBEEF at address 1.
  - Then a single `cpu_restart` pulse, and `cpu_hold` low 2 cycles after the last write.
- Back-to-back bytes: `rx_valid` held high for 10 cycles with a 2-word payload → both writes occur, no byte is lost, and `imem_we` is never high for two consecutive cycles.
- Oversize length: bytes 01 40 (0x4001) → ERR with `load_err` = 1 and `cpu_hold` = 1. A following `load_req` clears `load_err`.
- Zero length and `load_req` while busy:
  - Bytes 00 00 → DONE with no `imem_we`.
  - A `load_req` issued during DATA has no effect.
- Reset mid-word: pull `reset` low after 2 data bytes → `cpu_hold` = 0 and state IDLE. A new load then writes from address 0. With `IMEM_LOAD_CHECKSUM_EN`, a bad checksum byte → ERR and no restart.
